// File: rtl/avalon_mm_stream_reader.sv
// avalon_mm_stream_reader
//   Avalon-MM read master that walks a contiguous range of 32-bit words,
//   one outstanding read at a time, and buffers the returned words in a
//   show-ahead FIFO presented on a valid/ready stream.
//   Optional feature macro: AVMM_READER_LOOP_EN. When defined, the `loop`
//   input is added and the transfer repeats while it is high.
// Ports:
//   clock, reset_n            clock, synchronous active-low reset
//   start, base_addr,         transfer request (sampled in IDLE), byte base
//   word_count                address, number of 32-bit words
//   loop                      (AVMM_READER_LOOP_EN only) restart after last word
//   busy, done                transfer in progress, one-cycle completion pulse
//   m_address, m_read,        Avalon-MM read request towards the adapter
//   m_lock, m_waitrequest,
//   m_readdata,
//   m_readdatavalid
//   out_data, out_valid,      FIFO head stream towards the consumer
//   out_ready
module avalon_mm_stream_reader #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
`ifdef AVMM_READER_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_lock,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DATA, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               m_read_q, m_read_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;

  logic               accept_c, push_c, pop_c, room_c, last_c, wrap_c;
  logic [LEN_W-1:0]   rem_after_c;
  logic [ADDR_W-1:0]  base_aligned_c;
  logic               loop_c;
  logic [ADDR_W-1:0]  reload_addr_c;
  logic [LEN_W-1:0]   reload_len_c;

  assign base_aligned_c = base_addr & ~ADDR_W'(3);
  assign accept_c    = (state_q == S_REQ) && m_read_q && !m_waitrequest;
  // Data is only taken for our own single outstanding read
  assign push_c      = m_readdatavalid &&
                       (accept_c || (state_q == S_WAIT_DATA));
  assign pop_c       = out_valid_q && out_ready;
  assign room_c      = count_q < CNT_W'(DEPTH);
  assign rem_after_c = accept_c ? remaining_q - LEN_W'(1) : remaining_q;
  assign last_c      = push_c && (rem_after_c == '0);
  assign wrap_c      = last_c && loop_c;

`ifdef AVMM_READER_LOOP_EN
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;

  // Latched copies of the request, replayed on every loop pass
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      base_q <= '0;
      len_q  <= '0;
    end else if (state_q == S_IDLE && start) begin
      base_q <= base_aligned_c;
      len_q  <= word_count;
    end
  end

  assign loop_c        = loop;
  assign reload_addr_c = base_q;
  assign reload_len_c  = len_q;
`else
  assign loop_c        = 1'b0;
  assign reload_addr_c = '0;
  assign reload_len_c  = '0;
`endif

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      m_read_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      m_read_q    <= m_read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(push_c);
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clock) begin
    if (push_c) mem[wr_ptr_q] <= m_readdata;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (word_count == '0) ? S_FINISH : S_REQ;
      end
      S_REQ: begin
        if (accept_c) begin
          if (!m_readdatavalid)        state_d = S_WAIT_DATA;
          else if (last_c && !loop_c)  state_d = S_FINISH;
          else                         state_d = S_REQ;
        end
      end
      S_WAIT_DATA: begin
        if (m_readdatavalid) state_d = (last_c && !loop_c) ? S_FINISH : S_REQ;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    m_read_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_aligned_c;
          remaining_d = word_count;
        end
      end
      S_REQ: begin
        if (accept_c) begin
          addr_d      = addr_q + ADDR_W'(4);
          remaining_d = rem_after_c;
        end else begin
          // Hold a pending request; raise a new one only with FIFO room
          m_read_d = m_read_q || room_c;
        end
      end
      S_FINISH: addr_d = '0;
      default: ;
    endcase
    if (wrap_c) begin
      addr_d      = reload_addr_c;
      remaining_d = reload_len_c;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  // FIFO bookkeeping with a registered show-ahead head word
  always_comb begin
    count_d     = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
    out_valid_d = (count_d != '0);
    if (count_d == '0)
      out_data_d = '0;
    else if (count_q == CNT_W'(pop_c))
      out_data_d = m_readdata;   // FIFO empties this cycle; new word becomes head
    else
      out_data_d = mem[rd_ptr_d];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign m_lock    = busy_q;
  assign m_read    = m_read_q;
  assign m_address = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_avalon_mm_stream_reader.sv
// tb_avalon_mm_stream_reader
//   Directed table-driven bench for avalon_mm_stream_reader with a small
//   Avalon-MM slave responder and stream consumer. Loop checks are built
//   only when AVMM_READER_LOOP_EN is defined.
module tb_avalon_mm_stream_reader;

  localparam int unsigned ADDR_W = 27;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DEPTH  = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  word_count;
`ifdef AVMM_READER_LOOP_EN
  logic              loop;
`endif
  logic              busy, done, m_read, m_lock;
  logic [ADDR_W-1:0] m_address;
  logic              m_waitrequest;
  logic [31:0]       m_readdata;
  logic              m_readdatavalid;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  avalon_mm_stream_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .word_count(word_count),
`ifdef AVMM_READER_LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .done(done), .m_address(m_address), .m_read(m_read),
    .m_lock(m_lock), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder / consumer controls and observations
  int                waits = 0;
  int                dv_lat = 0;
  logic              ready_en = 1'b1;
  logic [ADDR_W-1:0] acc_q[$];
  logic [31:0]       pop_q[$];
  int                done_cnt = 0;
  int                lock_bad = 0;
  int                busy_late = 0;
  int                mread_cycles = 0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                cnt;
    int                waits;
    int                dv_lat;
    logic [ADDR_W-1:0] first;
    logic [ADDR_W-1:0] last;
  } vec_t;
  vec_t vt[5];

  function automatic logic [31:0] dat(input logic [ADDR_W-1:0] a);
    return {5'h15, a} ^ 32'h0F0F_0000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Slave + consumer: decisions made on the falling edge for the next rising edge
  initial begin
    int wcnt = 0;
    int pend = 0;
    logic [31:0] pend_data = '0;
    logic done_prev = 1'b0;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    m_readdata = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (done) begin
        done_cnt++;
        if (!m_lock || !busy) lock_bad++;
      end
      if (done_prev && busy) busy_late++;
      done_prev = done;
      if (m_read) mread_cycles++;
      out_ready = ready_en;
      if (out_valid && out_ready) pop_q.push_back(out_data);
      m_waitrequest = 1'b0;
      m_readdatavalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata = pend_data;
        end
      end else if (m_read) begin
        if (wcnt < waits) begin
          m_waitrequest = 1'b1;
          wcnt++;
        end else begin
          wcnt = 0;
          acc_q.push_back(m_address);
          if (dv_lat == 0) begin
            m_readdatavalid = 1'b1;
            m_readdata = dat(m_address);
          end else begin
            pend = dv_lat;
            pend_data = dat(m_address);
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic clear_obs();
    acc_q.delete();
    pop_q.delete();
    done_cnt = 0;
    lock_bad = 0;
    busy_late = 0;
    mread_cycles = 0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input int c);
    start = 1'b1;
    base_addr = b;
    word_count = LEN_W'(c);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!done && lat < 4000) begin
      @(negedge clock);
      lat++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  // Compare accepted addresses and popped words against the expected stream
  task automatic check_stream(input string tag, input logic [ADDR_W-1:0] base, input int cnt);
    logic [ADDR_W-1:0] a;
    int bad_a = -1;
    int bad_w = -1;
    chk({tag, "_reads"}, 64'(acc_q.size()), 64'(cnt));
    chk({tag, "_words"}, 64'(pop_q.size()), 64'(cnt));
    if (cnt == 0 || acc_q.size() < cnt || pop_q.size() < cnt) return;
    for (int i = 0; i < cnt; i++) begin
      a = (base & ~ADDR_W'(3)) + ADDR_W'(4 * i);
      if (bad_a < 0 && acc_q[i] !== a) bad_a = i;
      if (bad_w < 0 && pop_q[i] !== dat(a)) bad_w = i;
    end
    if (bad_a < 0) bad_a = cnt - 1;
    if (bad_w < 0) bad_w = cnt - 1;
    a = (base & ~ADDR_W'(3)) + ADDR_W'(4 * bad_a);
    chk({tag, "_addr_seq"}, 64'(acc_q[bad_a]), 64'(a));
    a = (base & ~ADDR_W'(3)) + ADDR_W'(4 * bad_w);
    chk({tag, "_data_seq"}, 64'(pop_q[bad_w]), 64'(dat(a)));
  endtask

  initial begin
    int lat;
    string tag;

    //              base          cnt waits dv_lat first         last
    vt[0] = '{27'h0000100,   4,  3,    0,     27'h0000100,  27'h000010C};
    vt[1] = '{27'h7FFFFFC,   2,  0,    0,     27'h7FFFFFC,  27'h0000000};
    vt[2] = '{27'h0000203,   3,  1,    1,     27'h0000200,  27'h0000208};
    vt[3] = '{27'h0000040,   0,  0,    0,     27'h0000000,  27'h0000000};
    vt[4] = '{27'h0001000,   5,  2,    1,     27'h0001000,  27'h0001010};

    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
`ifdef AVMM_READER_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_m_read", 64'(m_read), 64'd0);
    chk("rst_m_lock", 64'(m_lock), 64'd0);
    chk("rst_m_address", 64'(m_address), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);

    // Table-driven single transfers with a free-running consumer
    for (int v = 0; v < 5; v++) begin
      tag = $sformatf("vec%0d", v);
      clear_obs();
      ready_en = 1'b1;
      waits = vt[v].waits;
      dv_lat = vt[v].dv_lat;
      pulse_start(vt[v].base, vt[v].cnt);
      wait_done(tag, lat);
      if (vt[v].cnt == 0) begin
        chk({tag, "_latency_le2"}, 64'(lat <= 2), 64'd1);
      end
      repeat (12) @(negedge clock);
      check_stream(tag, vt[v].base, vt[v].cnt);
      if (vt[v].cnt == 0) begin
        chk({tag, "_no_m_read"}, 64'(mread_cycles), 64'd0);
      end else if (acc_q.size() == vt[v].cnt) begin
        chk({tag, "_first_addr"}, 64'(acc_q[0]), 64'(vt[v].first));
        chk({tag, "_last_addr"}, 64'(acc_q[vt[v].cnt - 1]), 64'(vt[v].last));
      end
      chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      chk({tag, "_lock_at_done"}, 64'(lock_bad), 64'd0);
      chk({tag, "_busy_after_done"}, 64'(busy_late), 64'd0);
      chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    end

    // Back-pressure: FIFO fills to DEPTH, requests stop, then everything drains
    clear_obs();
    ready_en = 1'b0;
    waits = 0;
    dv_lat = 0;
    pulse_start(27'h0000800, 20);
    repeat (150) @(negedge clock);
    chk("bp_reads_at_full", 64'(acc_q.size()), 64'(DEPTH));
    chk("bp_m_read_low", 64'(m_read), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_no_done", 64'(done_cnt), 64'd0);
    ready_en = 1'b1;
    wait_done("bp", lat);
    repeat (40) @(negedge clock);
    check_stream("bp", 27'h0000800, 20);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Reset while waiting for read data with three words buffered
    clear_obs();
    ready_en = 1'b0;
    waits = 0;
    dv_lat = 3;
    pulse_start(27'h0000300, 10);
    lat = 0;
    while (acc_q.size() < 4 && lat < 500) begin
      @(negedge clock);
      lat++;
    end
    chk("rst_mid_reached", 64'(acc_q.size()), 64'd4);
    @(negedge clock);
    chk("rst_mid_pre_valid", 64'(out_valid), 64'd1);
    chk("rst_mid_pre_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_m_read", 64'(m_read), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clock);
    chk("rst_mid_late_dv", 64'(out_valid), 64'd0);
    chk("rst_mid_idle_read", 64'(m_read), 64'd0);
    clear_obs();
    ready_en = 1'b1;
    dv_lat = 0;
    pulse_start(27'h0000500, 3);
    wait_done("post_rst", lat);
    repeat (10) @(negedge clock);
    check_stream("post_rst", 27'h0000500, 3);
    chk("post_rst_done_pulses", 64'(done_cnt), 64'd1);

`ifdef AVMM_READER_LOOP_EN
    // Looping pass: repeat 0x40,0x44 until loop drops, then finish the pass
    clear_obs();
    ready_en = 1'b1;
    waits = 0;
    dv_lat = 0;
    loop = 1'b1;
    pulse_start(27'h0000040, 2);
    lat = 0;
    while (acc_q.size() < 6 && lat < 500) begin
      @(negedge clock);
      lat++;
    end
    chk("loop_reads", 64'(acc_q.size() >= 6), 64'd1);
    if (acc_q.size() >= 6) begin
      chk("loop_a2", 64'(acc_q[2]), 64'h40);
      chk("loop_a5", 64'(acc_q[5]), 64'h44);
    end
    chk("loop_no_done", 64'(done_cnt), 64'd0);
    chk("loop_busy", 64'(busy), 64'd1);
    loop = 1'b0;
    wait_done("loop", lat);
    repeat (8) @(negedge clock);
    chk("loop_done_pulses", 64'(done_cnt), 64'd1);
    chk("loop_pass_whole", 64'(acc_q.size() % 2), 64'd0);
    chk("loop_last_addr", 64'(acc_q[acc_q.size() - 1]), 64'h44);
    chk("loop_words", 64'(pop_q.size()), 64'(acc_q.size()));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_mm_stream_reader.md
Name: avalon_mm_stream_reader

Overview:
Avalon-MM read master that sits directly upstream of the 32-to-16 read adapter. It walks a contiguous range of 32-bit words from a programmed base address, issuing one read at a time, and buffers the returned words in an internal show-ahead FIFO. It then presents them on a valid/ready stream to the picture/audio consumer.

Parameters:
ADDR_W, 27, byte-address width of m_address/base_addr
LEN_W, 16, width of word_count
DEPTH, 16, FIFO depth in 32-bit words (power of 2, >=2)

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a transfer (sampled only in IDLE)
base_addr  in  ADDR_W  byte start address; bits [1:0] forced to 0 when latched
word_count  in  LEN_W  number of 32-bit words to fetch
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last word has been received
m_address  out  ADDR_W  read address to adapter
m_read  out  1  read request
m_lock  out  1  high while busy
m_waitrequest  in  1  adapter stall
m_readdata  in  32  read data
m_readdatavalid  in  1  read data valid
out_data  out  32  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pop

Behaviour:
- Reset (reset_n low at a clock edge) returns the FSM to IDLE and empties the FIFO, including mid-transfer. Reset values: busy=0, done=0, m_read=0, m_lock=0, m_address=0, out_valid=0, out_data=0.
- FSM states: IDLE, REQ, WAIT_DATA, FINISH.
- IDLE, start=1:
  - Latch addr=base_addr&~3 and remaining=word_count.
  - If word_count==0, go to FINISH; no read is issued.
  - Otherwise go to REQ; busy=1, m_lock=1.
- REQ:
  - m_read=1, m_address=addr, but only while FIFO count<DEPTH. When the FIFO is full, m_read=0 and the FSM holds.
  - m_read and m_address stay stable while m_waitrequest=1.
  - On m_read=1 & m_waitrequest=0, the request is accepted. m_read drops on the next cycle, addr+=4 (wraps modulo 2^ADDR_W), remaining-=1.
  - If m_readdatavalid=1 in the same cycle as acceptance, the data is captured immediately. The adapter asserts both together, and this path is mandatory.
  - After acceptance, go to WAIT_DATA if data has not yet been captured. Otherwise go to REQ if remaining>0, else FINISH.
- WAIT_DATA: m_read=0. On m_readdatavalid=1, push m_readdata, then go to REQ if remaining>0, else FINISH.
- Outstanding reads: at most one, so there are no pipelined reads. The room check against DEPTH guarantees that a push never overflows.
- FINISH: done=1 for exactly one cycle, busy=0 and m_lock=0 on the next cycle, then IDLE.
- start while busy is ignored.
- m_readdatavalid outside REQ or WAIT_DATA is ignored.
- FIFO:
  - Show-ahead; out_valid = (count!=0), out_data = head word.
  - A word pushed at edge N is visible at the output after edge N.
  - A pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged; this is legal when full.
  - out_ready with FIFO empty has no effect.
  - The FIFO keeps draining after done; a new start is allowed while words remain.
- m_address is 0 whenever m_read=0 in IDLE. Elsewhere it holds addr.

Optional Feature:
Macro AVMM_READER_LOOP_EN.
- Defined: adds input port loop (1 bit). When the last word is received and loop=1, the block reloads addr=base and remaining=word_count (latched copies) and returns to REQ. In this case there is no done pulse and busy/m_lock stay high.
- If loop=0 at the last word, the block finishes normally.
- Deasserting loop never aborts the current pass.
- Not defined: the port is absent and every transfer ends after one pass.

Test Plan:
- start, base=0x100, count=4, adapter responds after 3 waitrequest cycles with readdatavalid on the acceptance cycle -> m_address sequence 0x100,0x104,0x108,0x10C; words pushed in order; single done pulse; busy falls the cycle after done.
- count=0 -> no m_read assertion; done pulses once, 1-2 cycles after start.
- out_ready=0, count=20, DEPTH=16 -> exactly 16 reads accepted, m_read held low. Then release out_ready -> the remaining 4 reads issue and all 20 words come out in order with no loss.
- base=0x7FFFFFC (ADDR_W=27), count=2 -> addresses 0x7FFFFFC then 0x0000000.
- Reset_n low while in WAIT_DATA with 3 words buffered -> next cycle out_valid=0, m_read=0, busy=0. A late m_readdatavalid is ignored; a new start works normally.
- With AVMM_READER_LOOP_EN and loop=1, base=0x40, count=2 -> addresses 0x40,0x44,0x40,0x44..., no done. Drop loop -> the pass completes and done pulses once.
